// File: rtl/urv_rf_wport_ctrl.sv
// urv_rf_wport_ctrl: arbitrates the register file write port between reset clear, writeback and debug writes
module urv_rf_wport_ctrl #(
  parameter int unsigned STARVE_LIMIT   = 8,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        d_stall_i,
  input  logic        w_rd_store_i,
  input  logic [4:0]  w_rd_i,
  input  logic [31:0] w_rd_value_i,
  input  logic        dbg_req_i,
  input  logic [4:0]  dbg_addr_i,
  input  logic [31:0] dbg_wdata_i,
  output logic        dbg_ack_o,
  output logic        pipe_hold_o,
  output logic        rf_init_done_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_a_o,
  output logic [31:0] rf_d_o
);
  typedef enum logic [1:0] {CLEAR, RUN, FORCE} state_e;
  localparam state_e RST_ST = CLEAR_ON_RESET ? CLEAR : RUN;
  localparam logic [7:0] LIM = 8'(STARVE_LIMIT);
  state_e      state_q, state_d;
  logic [4:0]  clr_q, clr_d;
  logic [7:0]  starve_q, starve_d;
  logic        ack_q, ack_d, done_q, done_d;
  logic        pw, dp, grant, we_c, hold_c;
  logic [4:0]  a_c;
  logic [31:0] d_c;
  // state register; the ack is a registered pulse following each debug grant
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= RST_ST;
      clr_q    <= 5'd1;
      starve_q <= '0;
      ack_q    <= 1'b0;
      done_q   <= !CLEAR_ON_RESET;
    end else begin
      state_q  <= state_d;
      clr_q    <= clr_d;
      starve_q <= starve_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
    end
  end
  // port arbitration: clear > writeback > debug, with FORCE breaking debug starvation
  always_comb begin
    pw       = w_rd_store_i && !d_stall_i && (w_rd_i != '0);
    dp       = dbg_req_i && !ack_q;
    state_d  = state_q;
    clr_d    = clr_q;
    starve_d = starve_q;
    grant    = 1'b0;
    we_c     = 1'b0;
    hold_c   = 1'b0;
    a_c      = '0;
    d_c      = '0;
    case (state_q)
      CLEAR: begin
        we_c     = 1'b1;
        a_c      = clr_q;
        hold_c   = 1'b1;
        clr_d    = clr_q + 5'd1;
        starve_d = '0;
        state_d  = (clr_q == 5'd31) ? RUN : CLEAR;
      end
      RUN: begin
        grant    = !pw && dp;
        we_c     = pw;
        a_c      = w_rd_i;
        d_c      = w_rd_value_i;
        starve_d = grant ? '0 : (dp && starve_q < LIM) ? starve_q + 8'd1 : starve_q;
        state_d  = (starve_d == LIM) ? FORCE : RUN;
      end
      FORCE: begin
        hold_c   = 1'b1;
        grant    = 1'b1;
        starve_d = '0;
        state_d  = RUN;
      end
      default: state_d = RST_ST;
    endcase
    if (grant) begin
      we_c = dbg_addr_i != '0;
      a_c  = dbg_addr_i;
      d_c  = dbg_wdata_i;
    end
    ack_d  = grant;
    done_d = done_q || (state_d == RUN);
  end
  assign dbg_ack_o      = ack_q;
  assign pipe_hold_o    = hold_c;
  assign rf_init_done_o = done_q;
  assign rf_we_o        = rst_n_i && we_c;
  assign rf_a_o         = rst_n_i ? a_c : '0;
  assign rf_d_o         = rst_n_i ? d_c : '0;
endmodule

// File: tb/tb_urv_rf_wport_ctrl.sv
// tb_urv_rf_wport_ctrl: scoreboard bench with a cycle-level reference model of the write port
module tb_urv_rf_wport_ctrl;
  localparam int LIM = 8;
  logic clk = 1'b0, rst_n = 1'b0, d_stall = 1'b0, w_rd_store = 1'b0, dbg_req = 1'b0;
  logic [4:0] w_rd = '0, dbg_addr = '0;
  logic [31:0] w_rd_value = '0, dbg_wdata = '0;
  logic ack0, hold0, done0, we0, ack1, hold1, done1, we1;
  logic [4:0] a0, a1;
  logic [31:0] d0, d1;
  typedef struct {
    bit we; bit ad; bit hold; bit ack; bit done;
    logic [4:0] a; logic [31:0] d;
  } exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  int clr_left = 31, lost = 0;
  bit ack_m = 0;
  bit req = 0;
  logic [4:0] addr = '0;
  logic [31:0] data = '0;
  always #5 clk = ~clk;
  urv_rf_wport_ctrl #(.STARVE_LIMIT(LIM), .CLEAR_ON_RESET(1'b1)) u0 (
    .clk_i(clk), .rst_n_i(rst_n), .d_stall_i(d_stall), .w_rd_store_i(w_rd_store),
    .w_rd_i(w_rd), .w_rd_value_i(w_rd_value), .dbg_req_i(dbg_req), .dbg_addr_i(dbg_addr),
    .dbg_wdata_i(dbg_wdata), .dbg_ack_o(ack0), .pipe_hold_o(hold0), .rf_init_done_o(done0),
    .rf_we_o(we0), .rf_a_o(a0), .rf_d_o(d0));
  urv_rf_wport_ctrl #(.STARVE_LIMIT(3), .CLEAR_ON_RESET(1'b0)) u1 (
    .clk_i(clk), .rst_n_i(rst_n), .d_stall_i(d_stall), .w_rd_store_i(w_rd_store),
    .w_rd_i(w_rd), .w_rd_value_i(w_rd_value), .dbg_req_i(dbg_req), .dbg_addr_i(dbg_addr),
    .dbg_wdata_i(dbg_wdata), .dbg_ack_o(ack1), .pipe_hold_o(hold1), .rf_init_done_o(done1),
    .rf_we_o(we1), .rf_a_o(a1), .rf_d_o(d1));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  task automatic cycle(input bit r, input bit st, input bit stl, input logic [4:0] rd, input logic [31:0] v);
    exp_t e;
    bit dpv, pwv, g;
    @(posedge clk);
    #1;
    rst_n = r; w_rd_store = st; d_stall = stl; w_rd = rd; w_rd_value = v;
    dbg_req = req; dbg_addr = addr; dbg_wdata = data;
    e = '{default: 0};
    e.ad = 1;
    g = 0;
    if (!r) begin
      e.hold = 1; clr_left = 31; lost = 0; ack_m = 0;
    end else begin
      dpv = req && !ack_m;
      pwv = st && !stl && rd != 0;
      e.ack = ack_m;
      e.done = clr_left == 0;
      if (clr_left > 0) begin
        e.hold = 1; e.we = 1; e.a = 5'(32 - clr_left); e.d = 0; clr_left--;
      end else if (lost == LIM) begin
        e.hold = 1; g = 1;
      end else if (pwv) begin
        e.we = 1; e.a = rd; e.d = v; lost += int'(dpv);
      end else if (dpv) g = 1;
      else e.ad = 0;
      if (g) begin
        e.we = addr != 0; e.a = addr; e.d = data; e.ad = e.we; lost = 0;
      end
      ack_m = g;
    end
    q.push_back(e);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      if (ack_m) req = 0;
      cycle(1, 0, 0, 5'd0, 32'd0);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ack", 32'(ack0), 32'(e.ack));
      chk("hold", 32'(hold0), 32'(e.hold));
      chk("init_done", 32'(done0), 32'(e.done));
      chk("we", 32'(we0), 32'(e.we));
      if (e.ad) begin
        chk("addr", 32'(a0), 32'(e.a));
        chk("data", d0, e.d);
      end
    end
  end
  initial begin
    logic [4:0] rd;
    cycle(0, 0, 0, 5'd0, 32'd0);
    cycle(0, 1, 0, 5'd7, 32'h1234_5678);
    @(negedge clk);
    chk("noclr_done_rst", 32'(done1), 32'd1);
    chk("noclr_hold_rst", 32'(hold1), 32'd0);
    chk("noclr_we_rst", 32'(we1), 32'd0);
    cycle(1, 1, 0, 5'd7, 32'h1234_5678);
    @(negedge clk);
    chk("noclr_we_first", 32'(we1), 32'd1);
    chk("noclr_a_first", 32'(a1), 32'd7);
    chk("noclr_d_first", d1, 32'h1234_5678);
    idle(19);
    req = 1; addr = 5'd5; data = 32'hDEAD_BEEF;
    idle(20);
    req = 1; addr = 5'd9; data = $urandom;
    for (int i = 0; i < 14; i++) begin
      if (ack_m) req = 0;
      rd = 5'($urandom_range(31, 1));
      cycle(1, 1, 0, rd, $urandom);
    end
    req = 1; addr = 5'd0; data = $urandom;
    for (int i = 0; i < 4; i++) begin
      if (ack_m) req = 0;
      cycle(1, 1, 0, 5'd0, $urandom);
    end
    cycle(0, 0, 0, 5'd0, 32'd0);
    req = 1; addr = 5'd3; data = 32'hA5A5_0003;
    idle(12);
    cycle(0, 0, 0, 5'd0, 32'd0);
    idle(36);
    for (int i = 0; i < 3000; i++) begin
      bit busy;
      busy = (i / 200) % 2 == 1;
      if (ack_m && req && $urandom_range(1) == 1) req = 0;
      else if (!req && $urandom_range(3) == 0) begin
        req = 1; addr = 5'($urandom); data = $urandom;
      end
      if ($urandom_range(999) == 0) cycle(0, 0, 0, 5'd0, 32'd0);
      else cycle(1, busy ? $urandom_range(9) != 0 : $urandom_range(1) == 1,
                 $urandom_range(7) == 0, 5'($urandom), $urandom);
    end
    @(negedge clk);
    #1;
    chk("drain", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/urv_rf_wport_ctrl.md
# urv_rf_wport_ctrl

Write-port controller for the uRV register file. It owns the single write port shared by both register banks and sequences three users of it:
- a hardware clear of x1..x31 after reset;
- the writeback stage;
- a debug-module write channel, with guaranteed forward progress against back-to-back writebacks.

It sits between the writeback stage / debug module and the `rf_a/rf_d/rf_we` inputs of the register file banks.

## Interface
Parameters:
- `STARVE_LIMIT`, 8: consecutive lost cycles before a pending debug write forces a pipeline hold. Legal range 1..255.
- `CLEAR_ON_RESET`, 1: 1 = zero x1..x31 after reset; 0 = go straight to RUN.

Ports:
- `clk_i` in 1: single clock.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `d_stall_i` in 1: pipeline stall; a writeback is valid only when low.
- `w_rd_store_i` in 1: writeback stage requests a register write.
- `w_rd_i` in 5: writeback destination.
- `w_rd_value_i` in 32: writeback data.
- `dbg_req_i` in 1: debug write request, level; held with addr/data until ack.
- `dbg_addr_i` in 5: debug destination register.
- `dbg_wdata_i` in 32: debug write data.
- `dbg_ack_o` out 1: one-cycle pulse, debug write completed.
- `pipe_hold_o` out 1: pipeline must OR this into its decode stall.
- `rf_init_done_o` out 1: register file clear complete.
- `rf_we_o` out 1: register file write enable.
- `rf_a_o` out 5: register file write address.
- `rf_d_o` out 32: register file write data.

## Operation
- State machine with three states: CLEAR, RUN, FORCE. Reset enters CLEAR if `CLEAR_ON_RESET`=1, else RUN.
- Pipeline write is valid (pw) when `w_rd_store_i` && !`d_stall_i` && `w_rd_i`!=0.
- Debug write is pending (dp) when `dbg_req_i` && !`dbg_ack_o`. A request sampled in its own ack cycle is never regranted.
- **CLEAR:**
  - 5-bit counter starts at 1. Each cycle: `rf_we_o`=1, `rf_a_o`=counter, `rf_d_o`=0; counter increments.
  - After writing x31, go to RUN.
  - `pipe_hold_o`=1 throughout. pw and dp are not serviced. The starve counter holds at 0.
- **RUN:**
  - If pw: drive the writeback fields onto the `rf_*` outputs, combinationally (zero latency).
  - Else if dp: grant debug. `rf_a_o`=`dbg_addr_i`, `rf_d_o`=`dbg_wdata_i`, `rf_we_o`=(`dbg_addr_i`!=0). `dbg_ack_o`=1 next cycle.
  - Else: `rf_we_o`=0.
- **Starve counter:**
  - Increments each RUN cycle in which dp is true and debug is not granted.
  - Clears on any debug grant. Saturates at `STARVE_LIMIT`.
  - When the count reaches `STARVE_LIMIT`, the next state is FORCE.
- **FORCE** (exactly one cycle):
  - `pipe_hold_o`=1. Debug is granted unconditionally and pw is ignored; the pipeline is stalled by `pipe_hold_o`, so writeback retries.
  - Return to RUN; `dbg_ack_o`=1 in that RUN cycle.
- Debug write to x0: granted and acked, but `rf_we_o` stays 0.
- `rf_init_done_o` is a registered flag. It is set on entry to RUN and stays set until reset.

## Timing
- Values while `rst_n_i` is low:
  - `dbg_ack_o`=0, `rf_we_o`=0, `rf_a_o`=0, `rf_d_o`=0.
  - `pipe_hold_o`=`CLEAR_ON_RESET`.
  - `rf_init_done_o`=!`CLEAR_ON_RESET`.
  - Starve counter=0, clear counter=1.
- CLEAR duration:
  - Cycles 0..30 after reset release write x1..x31.
  - Cycle 31 is RUN: `pipe_hold_o` falls and `rf_init_done_o` rises in that cycle.
- Pipeline write latency: 0 cycles, `rf_*` combinational from inputs in RUN.
- Debug write: grant in cycle N, register written at the edge ending N, `dbg_ack_o` high in N+1.
- Worst-case debug latency from `dbg_req_i` rise to ack, in RUN: `STARVE_LIMIT`+2 cycles.
- Reset mid-operation:
  - Asserting `rst_n_i` during CLEAR restarts the clear at x1.
  - An unacked debug request is dropped; the requester keeps `dbg_req_i` high and is serviced after the clear.
  - A pending ack is lost.
- Simultaneous pw and dp in RUN below the limit: pipeline wins and the starve counter increments.
- dp rising during CLEAR: waits. First service is in cycle 31, unless pw is also true in that cycle.

## Test plan
- **Reset clear:** reset release, `CLEAR_ON_RESET`=1 -> 31 writes of 0 to x1..x31 in order, `pipe_hold_o`=1 for cycles 0..30, `rf_init_done_o`=1 from cycle 31.
- **Idle debug write:** RUN, no pw, `dbg_req_i`=1, addr 5, data 0xDEADBEEF -> `rf_we_o`=1, `rf_a_o`=5 that cycle, `dbg_ack_o` pulse next cycle, no regrant while req is still high during the ack.
- **Starvation:** pw every cycle, `STARVE_LIMIT`=8, `dbg_req_i` held -> 8 pipeline writes, then FORCE: `pipe_hold_o`=1 for 1 cycle with the debug write, ack in the following cycle (latency 10).
- **x0 handling:** pw with `w_rd_i`=0 and debug write to x0 -> `rf_we_o` never asserted, debug still acked.
- **Reset mid-operation:** `rst_n_i` pulsed low at clear cycle 12 with `dbg_req_i` high -> clear restarts at x1, debug is granted at cycle 31 after release, exactly one ack.
- **No clear:** `CLEAR_ON_RESET`=0 -> `rf_init_done_o`=1 and `pipe_hold_o`=0 from reset, pipeline write passes in the first cycle.
